bus_master_if: RTL and testbench
================================

# bus_master_if

Bus-master-side interface unit: the requesting end of the round-robin shared-bus protocol. It accepts one single-word read or write from a core-side client (CPU fetch/memory stage or DMA), raises the active-low bus request to the arbiter, and waits for the active-low grant. Once granted, it performs one address-strobed access, waits for the slave's ready, then returns read data and releases the bus. One instance sits between each bus master (m0..m3) and the arbiter/shared bus.

## Interface
Parameters:
- ADDR_W, 30, word-address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (used only with BUS_TIMEOUT_EN); legal range 1..255

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  core access request, level; held until ack
- rw  in  1  1 = read, 0 = write
- addr  in  ADDR_W  core word address
- wr_data  in  DATA_W  core write data
- rd_data  out  DATA_W  registered read data
- ack  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with ack
- busy  out  1  core stall
- bus_req_  out  1  active-low request to arbiter
- bus_grnt_  in  1  active-low grant from arbiter
- bus_as_  out  1  active-low address strobe
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  ADDR_W  bus address
- bus_wr_data  out  DATA_W  bus write data
- bus_rd_data  in  DATA_W  slave read data
- bus_rdy_  in  1  active-low slave ready

## Operation
- FSM states: IDLE, REQ, ACCESS, WAIT.
- IDLE: on edge with req=1, latch rw/addr/wr_data into bus_rw/bus_addr/bus_wr_data, drive bus_req_=0, go to REQ.
- REQ: hold bus_req_=0. On edge with bus_grnt_=0, drive bus_as_=0, go to ACCESS. Otherwise stay; no time limit.
- ACCESS: bus_as_=0 for exactly one cycle. Next edge: bus_as_=1, go to WAIT. bus_rdy_ is not sampled in ACCESS.
- WAIT: on edge with bus_rdy_=0: if bus_rw=1, capture bus_rd_data into rd_data; pulse ack; bus_req_=1; go to IDLE.
- bus_grnt_ is sampled only in REQ. Grant deassertion in ACCESS/WAIT is ignored; the arbiter never revokes a grant while the request is held.
- bus_rw, bus_addr and bus_wr_data stay stable from the IDLE→REQ edge until the next transaction latches new values.
- rd_data holds its value until the next successful read. Writes and aborted reads leave it unchanged.
- busy = (state != IDLE) | (req & state == IDLE), combinational. It is therefore 1 in the cycle req first rises and drops in the cycle ack is high.
- Client must drop req, or present a new request, in the ack cycle. If req is still 1 at the edge following ack, a new transaction starts (back-to-back allowed).
- Reset (async, any state): state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, rd_data=0, ack=0, err=0. An in-flight transaction is dropped with no ack.

## Timing
- All outputs except busy are registered.
- Minimum latency, req sampled at E0 with grant already held at E1: ACCESS after E1, WAIT after E2, rdy_ sampled low at E3, ack high in cycle E3..E4. Total: 4 cycles from request edge to ack.
- Each extra arbitration cycle or slave wait-state cycle adds 1 cycle.
- bus_req_ deasserts on the same edge that raises ack. The arbiter may re-grant to another master on the following edge.

## Configuration
- BUS_TIMEOUT_EN defined:
  - 8-bit counter cleared on entering WAIT, incremented each WAIT cycle with bus_rdy_=1.
  - When count reaches TIMEOUT_CYCLES: ack=1 and err=1 for one cycle, bus_req_=1, go to IDLE, rd_data unchanged.
  - bus_rdy_=0 on the terminal cycle takes priority: normal completion, err=0.
- BUS_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; err is tied to 0.

## Test plan
- Read, grant already held, slave ready immediately: req=1, rw=1, addr=0x0000100, bus_rd_data=0xDEADBEEF → bus_as_ low exactly 1 cycle; ack at E3; rd_data=0xDEADBEEF; bus_req_ high with ack.
- Write, grant delayed 3 cycles, slave 2 wait states: wr_data=0x12345678 → bus_as_ low only after bus_grnt_ low; bus_wr_data=0x12345678 stable through WAIT; ack 9 cycles after request edge; rd_data unchanged.
- Back-to-back: req held high across ack with new addr=0x2 → new REQ on the edge after ack; bus_req_ high for exactly 1 cycle between transactions.
- Reset asserted mid-WAIT → bus_req_=1, bus_as_=1 and rd_data=0 immediately, without waiting for clk; no ack; after release, req=1 starts a clean transaction.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4), bus_rdy_ held high → ack=err=1 on the 4th WAIT edge; rd_data unchanged. With bus_rdy_=0 on that same edge → err=0, data captured.
- Timeout disabled (BUS_TIMEOUT_EN undefined): bus_rdy_ high for 1000 cycles → FSM stays in WAIT, busy=1, err=0.

Source files
------------

// File: rtl/bus_master_if.sv
//------------------------------------------------------------------------------
// bus_master_if : requesting end of the round-robin shared bus; one word per req.
// Optional macro BUS_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES with ack+err.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_master_if #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ack_q, ack_d;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_data_d     = rd_data_q;
    ack_d         = 1'b0;
`ifdef BUS_TIMEOUT_EN
    err_d         = 1'b0;
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          bus_rw_d      = rw;
          bus_addr_d    = addr;
          bus_wr_data_d = wr_data;
          bus_req_d     = 1'b0;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (!bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus_as_d = 1'b1;
        state_d  = S_WAIT;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = 8'd0;
`endif
      end
      S_WAIT: begin
        // A ready on the terminal timeout cycle still completes normally.
        if (!bus_rdy_) begin
          if (bus_rw_q) rd_data_d = bus_rd_data;
          ack_d     = 1'b1;
          bus_req_d = 1'b1;
          state_d   = S_IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          ack_d     = 1'b1;
          err_d     = 1'b1;
          bus_req_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_data_q     <= '0;
      ack_q         <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q         <= 1'b0;
      cnt_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_data_q     <= rd_data_d;
      ack_q         <= ack_d;
`ifdef BUS_TIMEOUT_EN
      err_q         <= err_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign rd_data     = rd_data_q;
  assign ack         = ack_q;
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign busy        = (state_q != S_IDLE) | req;

`ifdef BUS_TIMEOUT_EN
  assign err = err_q;
`else
  // No timeout path: TIMEOUT_CYCLES is at least 1, so this is constant 0.
  assign err = ack_q & (TIMEOUT_CYCLES == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: a transaction-table model predicts every output cycle by cycle.
`default_nettype none

module tb_bus_master_if;
  localparam int AW = 30, DW = 32, TO = 4, NT = 9, LAST = 1095, RST_C = 50;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, req, rw, ack, err, busy;
  logic          bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [AW-1:0] addr, bus_addr;
  logic [DW-1:0] wr_data, rd_data, bus_wr_data, bus_rd_data;

  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack), .err(err), .busy(busy),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  // s: edge that samples req; g: arbitration delay; w: slave wait states; kill: reset edge
  typedef struct {
    int            s;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    int            g;
    int            w;
    int            kill;
  } txn_t;

  txn_t T[NT];
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;

  function automatic bit aborts(int i);
    return TO_EN && (T[i].w >= TO);
  endfunction

  // Edge on which the transaction completes (ack visible in the following cycle).
  function automatic int edone(int i);
    if (aborts(i)) return T[i].s + 2 + T[i].g + TO;
    return T[i].s + 3 + T[i].g + T[i].w;
  endfunction

  task automatic add(input int i, input int s, input bit r, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                     input int g, input int w, input int kill);
    T[i].s = s; T[i].rw = r; T[i].addr = a; T[i].wd = wd; T[i].rd = rd;
    T[i].g = g; T[i].w = w; T[i].kill = kill;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    else
      npass++;
  endtask

  task automatic drive(input int E);
    req = 1'b0; rw = 1'b1; addr = '0; wr_data = '0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hFFFF0000;
    for (int i = 0; i < NT; i++) begin
      if (E >= T[i].s && E <= edone(i) && E < T[i].kill) begin
        req = 1'b1; rw = T[i].rw; addr = T[i].addr; wr_data = T[i].wd;
        bus_rd_data = T[i].rd;
        if (E >= T[i].s + 1 + T[i].g) bus_grnt_ = 1'b0;
        // Ready is also offered on the ACCESS edge, where it must be ignored.
        if (E == T[i].s + 2 + T[i].g || E == T[i].s + 3 + T[i].g + T[i].w) bus_rdy_ = 1'b0;
      end
    end
  endtask

  task automatic check_cycle(input int c);
    logic          e_req, e_as, e_ack, e_err, e_busy, e_rw, act;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    int            ed;
    if (c == 1 || (c >= RST_C && c <= RST_C + 2)) begin
      chk("rst_bus_req_", bus_req_, 1'b1);
      chk("rst_bus_as_", bus_as_, 1'b1);
      chk("rst_ack_err", {ack, err}, 2'b00);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_bus_fields", {bus_rw, bus_addr, bus_wr_data}, {1'b1, 30'h0, 32'h0});
      return;
    end
    e_req = 1'b1; e_as = 1'b1; e_ack = 1'b0; e_err = 1'b0; e_busy = 1'b0; act = 1'b0;
    e_rw = 1'b1; e_addr = '0; e_wd = '0; e_rd = '0;
    for (int i = 0; i < NT; i++) begin
      ed = edone(i);
      if (T[i].s == c + 1) e_busy = 1'b1;
      if (c >= T[i].s && c <= ed && c < T[i].kill) begin
        act = 1'b1;
        e_rw = T[i].rw; e_addr = T[i].addr; e_wd = T[i].wd;
        e_req = (c == ed);
        e_as = (c != T[i].s + 1 + T[i].g);
        e_ack = (c == ed);
        e_err = e_ack && aborts(i);
        if (c < ed) e_busy = 1'b1;
      end
      if (ed <= c && ed < T[i].kill && T[i].rw && !aborts(i) && !(c >= RST_C && ed < RST_C))
        e_rd = T[i].rd;
    end
    chk("bus_req_", bus_req_, e_req);
    chk("bus_as_", bus_as_, e_as);
    chk("ack", ack, e_ack);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("rd_data", rd_data, e_rd);
    if (act) chk("bus_fields", {bus_rw, bus_addr, bus_wr_data}, {e_rw, e_addr, e_wd});
    // Hand-computed pins of the model's timing.
    if (c == 4)  chk("pin_no_early_ack", ack, 1'b0);
    if (c == 5)  chk("pin_read_ack", {ack, rd_data}, {1'b1, 32'hDEADBEEF});
    if (c == 16) chk("pin_write_ack", {ack, bus_wr_data, rd_data}, {1'b1, 32'h12345678, 32'hDEADBEEF});
    if (c == 25) chk("pin_b2b_release", bus_req_, 1'b1);
    if (c == 26) chk("pin_b2b_rereq", {bus_req_, bus_addr}, {1'b0, 30'h2});
`ifdef BUS_TIMEOUT_EN
    if (c == 76) chk("pin_timeout", {ack, err, rd_data}, {2'b11, 32'h13579BDF});
`else
    if (c == 1072) chk("pin_long_wait", {busy, err, ack}, 3'b100);
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_cycle(cyc);
    end
  end

  initial begin
    add(0, 2,    1'b1, 30'h100, 32'h0,        32'hDEADBEEF, 0, 0,    1 << 30);
    add(1, 8,    1'b0, 30'h55,  32'h12345678, 32'h5555AAAA, 3, 2,    1 << 30);
    add(2, 20,   1'b1, 30'h1,   32'h0,        32'hA5A5A5A5, 1, 1,    1 << 30);
    add(3, 26,   1'b1, 30'h2,   32'h0,        32'h0BADF00D, 0, 3,    1 << 30);
    add(4, 35,   1'b0, 30'h3,   32'hCAFEF00D, 32'h5555AAAA, 0, 0,    1 << 30);
    add(5, 45,   1'b1, 30'h4,   32'h0,        32'h11111111, 0, 100,  RST_C);
    add(6, 60,   1'b1, 30'h7,   32'h0,        32'h13579BDF, 0, 0,    1 << 30);
    add(7, 70,   1'b1, 30'h8,   32'h0,        32'h2468ACE0, 0, TO_EN ? 10 : 1000, 1 << 30);
    add(8, 1080, 1'b1, 30'h9,   32'h0,        32'h0F0F0F0F, 2, TO_EN ? 3 : 0, 1 << 30);
    reset = 1'b1;
    drive(1);
    for (int E = 1; E <= LAST; E++) begin
      if (E == 2 || E == RST_C + 3) reset = 1'b0;
      if (E > 1) drive(E);
      if (E == RST_C + 1) begin
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_bus_req_", bus_req_, 1'b1);
        chk("async_rst_bus_as_", bus_as_, 1'b1);
        chk("async_rst_rd_data", rd_data, 32'h0);
        chk("async_rst_ack", ack, 1'b0);
      end
      @(posedge clk);
      cyc = E;
      #1;
    end
    #10;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
